// File: rtl/rr_pri_arbiter.sv
// -----------------------------------------------------------------------------
// rr_pri_arbiter
//
// Round-robin arbiter that shares one downstream resource between N
// requesters. The winner is picked by a rotating-priority encoder: requests
// above the last owner (ptr) are considered first, lowest index wins, and if
// none exist the search wraps to plain lowest-index priority. A grant is held
// while its owner keeps requesting, but a hold counter forces a handover after
// MAX_HOLD consecutive cycles so no requester can starve the others.
//
// Ports
//   clk        in   1      clock, all state updates on posedge
//   rst_n      in   1      asynchronous active-low reset
//   req        in   N      level requests, held until served
//   gnt        out  N      registered one-hot grant, all zero when idle
//   gnt_idx    out  N_LOG  index of current owner, 0 when idle
//   gnt_valid  out  1      high while any grant is asserted
//   timeout    out  1      one-cycle pulse when an owner is forced off
//
// Parameters
//   N         number of requesters (2..64)
//   N_LOG     width of gnt_idx, ceil(log2(N))
//   MAX_HOLD  max consecutive grant cycles per tenure (1..255), 0 = unlimited
// -----------------------------------------------------------------------------
module rr_pri_arbiter #(
    parameter int N        = 8,
    parameter int N_LOG    = 3,
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    output logic [N-1:0]     gnt,
    output logic [N_LOG-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             timeout
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } state_t;

    localparam logic [7:0]       HOLD_LIMIT = 8'(MAX_HOLD);
    localparam logic [N_LOG-1:0] PTR_RESET  = N_LOG'(N - 1);

    // One-hot decode of an index.
    function automatic logic [N-1:0] onehot_f(input logic [N_LOG-1:0] idx);
        logic [N-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Thermometer mask selecting indices strictly above p. With p = N-1 the
    // mask is empty, which makes the search wrap to index 0.
    function automatic logic [N-1:0] above_mask_f(input logic [N_LOG-1:0] p);
        logic [N-1:0] m;
        m = '0;
        for (int i = 0; i < N; i++) begin
            m[i] = (i > int'(p)) ? 1'b1 : 1'b0;
        end
        return m;
    endfunction

    // Index of the lowest set bit (0 when v is all zero).
    function automatic logic [N_LOG-1:0] lowest_f(input logic [N-1:0] v);
        logic [N_LOG-1:0] idx;
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = v[i] ? N_LOG'(i) : idx;
        end
        return idx;
    endfunction

    // Rotating-priority winner: lowest request above p, else lowest overall.
    function automatic logic [N_LOG-1:0] win_f(input logic [N-1:0]     v,
                                               input logic [N_LOG-1:0] p);
        logic [N-1:0] masked;
        masked = v & above_mask_f(p);
        return (masked != '0) ? lowest_f(masked) : lowest_f(v);
    endfunction

    state_t           state_r;
    logic [N_LOG-1:0] ptr_r;
    logic [7:0]       hold_cnt_r;

    state_t           state_nx_s;
    logic [N_LOG-1:0] ptr_nx_s;
    logic [7:0]       hold_nx_s;
    logic             timeout_nx_s;

    logic [N-1:0]     owner_bit_s;
    logic             owner_req_s;
    logic [N-1:0]     others_s;
    logic             limit_hit_s;
    logic [7:0]       hold_inc_s;

    // Owner-relative views of the request vector and the hold limit.
    always_comb begin
        owner_bit_s = onehot_f(ptr_r);
        owner_req_s = |(req & owner_bit_s);
        others_s    = req & ~owner_bit_s;
        limit_hit_s = (MAX_HOLD != 0) && (hold_cnt_r >= HOLD_LIMIT);
        hold_inc_s  = (hold_cnt_r == 8'hFF) ? 8'hFF : (hold_cnt_r + 8'd1);
    end

    // Next-state decision: grant, hold, hand over or go idle.
    always_comb begin
        state_nx_s   = state_r;
        ptr_nx_s     = ptr_r;
        hold_nx_s    = hold_cnt_r;
        timeout_nx_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req != '0) begin
                    state_nx_s = ST_OWN;
                    ptr_nx_s   = win_f(req, ptr_r);
                    hold_nx_s  = 8'd1;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_OWN: begin
                if (owner_req_s && !limit_hit_s) begin
                    hold_nx_s = hold_inc_s;
                end else if (others_s != '0) begin
                    // Owner released or hit the limit: hand over directly,
                    // excluding the old owner, with no idle bubble.
                    ptr_nx_s     = win_f(others_s, ptr_r);
                    hold_nx_s    = 8'd1;
                    timeout_nx_s = owner_req_s;
                end else if (owner_req_s) begin
                    // Limit hit but nobody else waiting: re-grant same owner.
                    hold_nx_s    = 8'd1;
                    timeout_nx_s = 1'b1;
                end else begin
                    state_nx_s = ST_IDLE;
                    hold_nx_s  = 8'd0;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
                ptr_nx_s   = PTR_RESET;
                hold_nx_s  = 8'd0;
            end
        endcase
    end

    // State, pointer, hold counter and registered grant outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            ptr_r      <= PTR_RESET;
            hold_cnt_r <= 8'd0;
            gnt        <= '0;
            gnt_idx    <= '0;
            gnt_valid  <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            state_r    <= state_nx_s;
            ptr_r      <= ptr_nx_s;
            hold_cnt_r <= hold_nx_s;
            timeout    <= timeout_nx_s;
            if (state_nx_s == ST_OWN) begin
                gnt       <= onehot_f(ptr_nx_s);
                gnt_idx   <= ptr_nx_s;
                gnt_valid <= 1'b1;
            end else begin
                gnt       <= '0;
                gnt_idx   <= '0;
                gnt_valid <= 1'b0;
            end
        end
    end

endmodule
